mem_stage_vlat: RTL

- Parametrised successor to the fixed single-cycle MEM pipeline stage of the LoongArch 5-stage core.
- Accepts EX-stage results and waits for variable-latency data-memory responses using a data_ok handshake.
- Aligns and sign/zero-extends load data, then hands the writeback bundle to WB.
- Supports pipeline flush, discards responses that belong to cancelled requests, and exports forwarding/stall info to ID.

---
 rtl/mem_stage_vlat.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_stage_vlat.sv
// mem_stage_vlat: MEM pipeline stage that waits for variable-latency data_ok responses,
// aligns/extends load data, and drops responses belonging to flushed requests.
module mem_stage_vlat #(
    parameter int DATA_W          = 32,
    parameter int PC_W            = 32,
    parameter int RA_W            = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [PC_W-1:0]   es_pc,
    input  logic [DATA_W-1:0] es_result,
    input  logic              es_rf_we,
    input  logic [RA_W-1:0]   es_rf_waddr,
    input  logic [4:0]        es_ld_op,
    input  logic              es_mem_req,
    input  logic              ms_flush,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [PC_W-1:0]   ms_pc,
    output logic              ms_rf_we,
    output logic [RA_W-1:0]   ms_rf_waddr,
    output logic [DATA_W-1:0] ms_rf_wdata,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              ms_fwd_stall,
    output logic              ms_req_block
);
    localparam int LW = $clog2(DATA_W / 8);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic              r_valid, r_data_got, r_rf_we, r_mem_req;
    logic [DATA_W-1:0] r_rdata_buf, r_result;
    logic [PC_W-1:0]   r_pc;
    logic [RA_W-1:0]   r_waddr;
    logic [4:0]        r_ld_op;
    logic [CW-1:0]     r_drop_cnt;

    logic              w_drop_zero, w_ready_go, w_accept, w_leave, w_consume;
    logic              w_inc_ms, w_inc_es, w_dec;
    logic [DATA_W-1:0] w_raw, w_load;
    logic [LW-1:0]     w_off;
    logic [31:0]       w_word;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;

    assign w_drop_zero    = r_drop_cnt == '0;
    assign w_ready_go     = ~r_mem_req | r_data_got | (data_ok & w_drop_zero);
    assign ms_allowin     = ~r_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_valid & w_ready_go & ~ms_flush;
    assign w_accept       = es_to_ms_valid & ms_allowin & ~ms_flush;
    assign w_leave        = ms_to_ws_valid & ws_allowin;
    assign w_consume      = data_ok & w_drop_zero & r_valid & r_mem_req & ~r_data_got;
    // A response arriving with the flush is consumed by the MEM entry, so it is not owed.
    assign w_inc_ms       = ms_flush & r_valid & r_mem_req & ~r_data_got & ~(data_ok & w_drop_zero);
    assign w_inc_es       = ms_flush & es_to_ms_valid & es_mem_req;
    assign w_dec          = data_ok & ~w_drop_zero;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid     <= 1'b0;
            r_data_got  <= 1'b0;
            r_rdata_buf <= '0;
            r_drop_cnt  <= '0;
            r_pc        <= '0;
            r_result    <= '0;
            r_rf_we     <= 1'b0;
            r_waddr     <= '0;
            r_ld_op     <= '0;
            r_mem_req   <= 1'b0;
        end else begin
            r_drop_cnt <= r_drop_cnt + CW'(w_inc_ms) + CW'(w_inc_es) - CW'(w_dec);
            if (w_accept) begin
                r_valid    <= 1'b1;
                r_data_got <= 1'b0;
                r_pc       <= es_pc;
                r_result   <= es_result;
                r_rf_we    <= es_rf_we;
                r_waddr    <= es_rf_waddr;
                r_ld_op    <= es_ld_op;
                r_mem_req  <= es_mem_req;
            end else if (ms_flush | w_leave) begin
                r_valid    <= 1'b0;
                r_data_got <= 1'b0;
            end else if (w_consume) begin
                r_data_got  <= 1'b1;
                r_rdata_buf <= data_rdata;
            end
        end
    end

    // Lane offsets are masked down to the access size so the same shift works for any DATA_W.
    assign w_raw  = r_data_got ? r_rdata_buf : data_rdata;
    assign w_off  = r_result[LW-1:0];
    assign w_word = 32'(w_raw >> {w_off & ~LW'(3), 3'b000});
    assign w_half = 16'(w_raw >> {w_off & ~LW'(1), 3'b000});
    assign w_byte = 8'(w_raw >> {w_off, 3'b000});
    assign w_load = r_ld_op[4] ? DATA_W'(w_word) :
                    (r_ld_op[3] | r_ld_op[2]) ? {{(DATA_W-16){r_ld_op[3] & w_half[15]}}, w_half} :
                    {{(DATA_W-8){r_ld_op[1] & w_byte[7]}}, w_byte};

    assign ms_pc        = r_pc;
    assign ms_rf_we     = r_rf_we & r_valid;
    assign ms_rf_waddr  = r_waddr;
    assign ms_rf_wdata  = (|r_ld_op) ? w_load : r_result;
    assign ms_fwd_stall = r_valid & (|r_ld_op) & ~w_ready_go;
    assign ms_req_block = ~w_drop_zero;
endmodule
